// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// State encoding, digit limits and the digit validity helper.
package bcd_serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ADD   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [4:0] BCD_MAX  = 5'd9;
   localparam logic [4:0] BCD_CORR = 5'd6;

   function automatic logic digit_bad(input logic [3:0] d);
      return {1'b0, d} > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Single-digit BCD adder slice with carry in/out.
// Purely combinational; input digits are assumed valid.
module bcd_digit_add
   import bcd_serial_add_ctrl_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] t;
   logic [4:0] tc;

   always_comb begin
      t  = {1'b0, x} + {1'b0, y} + {4'd0, ci};
      tc = t + BCD_CORR;
      co = t > BCD_MAX;
      s  = co ? tc[3:0] : t[3:0];
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer stepping one shared BCD digit slice across DIGITS digits.
// Captures operands on start, validates them, then ripples LSD to MSD.
module bcd_serial_add_ctrl
   import bcd_serial_add_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [4*DIGITS-1:0] a_i,
   input  logic [4*DIGITS-1:0] b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [4*DIGITS-1:0] sum_o,
   output logic                cout_o,
   output logic                err_o
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          err_q, err_d;
   logic          carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;

   logic [3:0] x_dig, y_dig, s_dig;
   logic       co;
   logic       bad;

   always_comb begin
      x_dig = '0;
      y_dig = '0;
      bad   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            x_dig = a_q[4*i +: 4];
            y_dig = b_q[4*i +: 4];
         end
         bad = bad | digit_bad(a_q[4*i +: 4])
                   | digit_bad(b_q[4*i +: 4]);
      end
   end

   bcd_digit_add u_slice (
      .x  (x_dig),
      .y  (y_dig),
      .ci (carry_q),
      .s  (s_dig),
      .co (co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               sum_d   = '0;
               cout_d  = 1'b0;
               err_d   = 1'b0;
               carry_d = 1'b0;
               idx_d   = '0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (bad) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (IW'(i) == idx_q) sum_d[4*i +: 4] = s_dig;
            end
            carry_d = co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               cout_d  = co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   assign busy_o = (state_q == ST_CHECK) || (state_q == ST_ADD);
   assign done_o = (state_q == ST_DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized self-checking bench for bcd_serial_add_ctrl.
// Reference model works on decimal integers, not on digit steps.
module tb_bcd_serial_add_ctrl;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         start_i;
   logic [W-1:0] a_i, b_i;
   logic         busy_o, done_o, cout_o, err_o;
   logic [W-1:0] sum_o;

   int checks = 0;
   int failures = 0;

   bcd_serial_add_ctrl #(.DIGITS(D)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sum_o   (sum_o),
      .cout_o  (cout_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit all_valid(input logic [W-1:0] v);
      for (int i = 0; i < D; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int to_int(input logic [W-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int n);
      logic [W-1:0] r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && ($urandom_range(0, 5) == 0))
         r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      return r;
   endfunction

   task automatic wait_done(input string tag);
      int n;
      for (n = 0; n < 20; n++) begin
         if (done_o) break;
         @(negedge clk_i);
      end
      chk({tag, "_drain_timeout"}, 64'(n < 20), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
      int lim, mod, exp_lat, lat, n;
      logic [W-1:0] e_sum;
      logic e_cout, e_err;
      bit busy_ok;
      lim = 1;
      for (int i = 0; i < D; i++) lim = lim * 10;
      if (all_valid(a) && all_valid(b)) begin
         mod     = to_int(a) + to_int(b);
         e_cout  = mod >= lim;
         e_sum   = to_bcd(mod % lim);
         e_err   = 1'b0;
         exp_lat = D + 2;
      end else begin
         e_cout  = 1'b0;
         e_sum   = '0;
         e_err   = 1'b1;
         exp_lat = 2;
      end
      @(negedge clk_i);
      a_i = a;
      b_i = b;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = hold;
      lat = 0;
      busy_ok = 1'b1;
      for (n = 1; n <= 20; n++) begin
         if (done_o) begin
            lat = n;
            break;
         end
         busy_ok &= busy_o;
         a_i = W'($urandom);
         b_i = W'($urandom);
         @(negedge clk_i);
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
      chk({tag, "_sum"}, 64'(sum_o), 64'(e_sum));
      chk({tag, "_cout"}, 64'(cout_o), 64'(e_cout));
      chk({tag, "_err"}, 64'(err_o), 64'(e_err));
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      chk({tag, "_idle"}, 64'(busy_o), 64'd0);
      chk({tag, "_hold_sum"}, 64'(sum_o), 64'(e_sum));
      if (hold) begin
         @(negedge clk_i);
         chk({tag, "_restart"}, 64'(busy_o), 64'd1);
         start_i = 1'b0;
         wait_done(tag);
         @(negedge clk_i);
      end
   endtask

   initial begin
      int n;
      bit saw_done;
      rst_i = 1'b1;
      start_i = 1'b1;
      a_i = 16'h1234;
      b_i = 16'h5678;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_sum", 64'(sum_o), 64'd0);
      chk("rst_cout", 64'(cout_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      start_i = 1'b0;
      rst_i = 1'b0;

      run_op("p1", 16'h1234, 16'h5678, 1'b0);
      run_op("p2", 16'h9999, 16'h0001, 1'b0);
      run_op("p3", 16'h9999, 16'h9999, 1'b0);
      run_op("p4", 16'h12A4, 16'h0001, 1'b0);
      run_op("p4b", 16'h0000, 16'hF000, 1'b0);
      run_op("p5", 16'h4567, 16'h5555, 1'b1);

      // abort mid-ADD: cycle 4 after start is the third ADD cycle
      @(negedge clk_i);
      a_i = 16'h1234;
      b_i = 16'h5678;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("p6_in_add", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("p6_busy", 64'(busy_o), 64'd0);
      chk("p6_done", 64'(done_o), 64'd0);
      chk("p6_sum", 64'(sum_o), 64'd0);
      chk("p6_cout", 64'(cout_o), 64'd0);
      chk("p6_err", 64'(err_o), 64'd0);
      saw_done = 1'b0;
      for (n = 0; n < 8; n++) begin
         saw_done |= done_o | busy_o;
         @(negedge clk_i);
      end
      chk("p6_no_done", 64'(saw_done), 64'd0);
      run_op("p6_new", 16'h0005, 16'h0005, 1'b0);

      for (int k = 0; k < 40; k++)
         run_op($sformatf("rnd%0d", k), rand_bcd(1'b1), rand_bcd(1'b1),
                1'(($urandom_range(0, 3) == 0)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
